// File: rtl/tl_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_sensor_conditioner_if
// Description : Field-input / conditioned-output bundle between the sensor
//               front end and the traffic light controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_sensor_conditioner_if;
    logic raw_car;
    logic raw_ped_btn;
    logic raw_emergency;
    logic ped_ack;
    logic sensor_car;
    logic sensor_pedestrian;
    logic emergency;
    logic sensor_fault;

    modport master (
        output raw_car, raw_ped_btn, raw_emergency, ped_ack,
        input  sensor_car, sensor_pedestrian, emergency, sensor_fault
    );

    modport slave (
        input  raw_car, raw_ped_btn, raw_emergency, ped_ack,
        output sensor_car, sensor_pedestrian, emergency, sensor_fault
    );
endinterface
`default_nettype wire

// File: rtl/tl_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tl_sensor_conditioner
// Description : Synchronizes and debounces car / pedestrian / emergency field
//               inputs; latches pedestrian requests until acknowledged.
//               Optional stuck-car monitor enabled by TL_SENSOR_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_sensor_conditioner #(
    parameter int DB_CYCLES   = 4,
    parameter int STUCK_LIMIT = 255
) (
    input  wire logic               clk,
    input  wire logic               rst,
    tl_sensor_conditioner_if.slave  sc
);

    localparam int          c_num_ch  = 3;
    localparam int          c_ch_car  = 0;
    localparam int          c_ch_ped  = 1;
    localparam int          c_ch_emg  = 2;
    localparam logic [3:0]  c_db_last = 4'(DB_CYCLES - 1);

    logic [c_num_ch-1:0] w_raw;
    logic [c_num_ch-1:0] r_s1;
    logic [c_num_ch-1:0] r_s2;
    logic [c_num_ch-1:0] w_stable_q;
    logic [c_num_ch-1:0] w_stable_d;
    logic                w_ped_rise;
    logic                r_ped_latch;

    assign w_raw = {sc.raw_emergency, sc.raw_ped_btn, sc.raw_car};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_chan
            // The emergency channel asserts on the first synchronized high.
            localparam bit c_fast_set = (gi == c_ch_emg);

            logic       r_stable;
            logic [3:0] r_cnt;
            logic       w_stable_nxt;
            logic [3:0] w_cnt_nxt;

            always_comb begin
                w_stable_nxt = r_stable;
                w_cnt_nxt    = r_cnt;
                if (r_s2[gi] == r_stable) begin
                    w_cnt_nxt = 4'd0;
                end else if (c_fast_set && r_s2[gi]) begin
                    w_stable_nxt = 1'b1;
                    w_cnt_nxt    = 4'd0;
                end else if (r_cnt == c_db_last) begin
                    w_stable_nxt = ~r_stable;
                    w_cnt_nxt    = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stable <= 1'b0;
                    r_cnt    <= 4'd0;
                end else begin
                    r_stable <= w_stable_nxt;
                    r_cnt    <= w_cnt_nxt;
                end
            end

            assign w_stable_q[gi] = r_stable;
            assign w_stable_d[gi] = w_stable_nxt;
        end
    endgenerate

    // A new request beats a coincident acknowledge.
    assign w_ped_rise = ~w_stable_q[c_ch_ped] & w_stable_d[c_ch_ped];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_latch <= 1'b0;
        end else if (w_ped_rise) begin
            r_ped_latch <= 1'b1;
        end else if (sc.ped_ack) begin
            r_ped_latch <= 1'b0;
        end
    end

    assign sc.sensor_pedestrian = r_ped_latch;
    assign sc.emergency         = w_stable_q[c_ch_emg];

`ifdef TL_SENSOR_FAULT_EN
    localparam logic [7:0] c_stuck_limit = 8'(STUCK_LIMIT);

    logic [7:0] r_stuck_cnt;
    logic       r_fault;
    logic       r_car_out;
    logic       w_fault_nxt;

    assign w_fault_nxt = r_fault |
                         (w_stable_q[c_ch_car] && (r_stuck_cnt == c_stuck_limit - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stuck_cnt <= 8'd0;
            r_fault     <= 1'b0;
            r_car_out   <= 1'b0;
        end else begin
            if (!w_stable_q[c_ch_car]) begin
                r_stuck_cnt <= 8'd0;
            end else if (r_stuck_cnt != c_stuck_limit) begin
                r_stuck_cnt <= r_stuck_cnt + 8'd1;
            end
            r_fault   <= w_fault_nxt;
            // Fail-safe: a stuck loop keeps the car direction requested.
            r_car_out <= w_stable_d[c_ch_car] | w_fault_nxt;
        end
    end

    assign sc.sensor_car   = r_car_out;
    assign sc.sensor_fault = r_fault;
`else
    logic w_unused_limit;

    // Keeps the limit referenced in builds without the stuck-car monitor.
    assign w_unused_limit = ^8'(STUCK_LIMIT);
    assign sc.sensor_car   = w_stable_q[c_ch_car];
    assign sc.sensor_fault = 1'b0;
`endif

endmodule
`default_nettype wire
